// File: rtl/cache_pkg.sv
// cache_pkg: shared state encoding, default widths and status bit positions for the cache controller
package cache_pkg;
  localparam int DEF_TAG_W  = 3;
  localparam int DEF_IDX_W  = 2;
  localparam int DEF_DATA_W = 3;
  localparam int DEF_CNT_W  = 8;
  localparam int ST_LRU0   = 0;
  localparam int ST_LRU1   = 1;
  localparam int ST_VALID0 = 2;
  localparam int ST_VALID1 = 3;
  localparam int ST_DIRTY0 = 4;
  localparam int ST_DIRTY1 = 5;
  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;
endpackage

// File: rtl/cache_if.sv
// cache_if: requester and memory-side signals of the cache controller; slave = controller, master = environment
interface cache_if #(
  parameter int TAG_W  = cache_pkg::DEF_TAG_W,
  parameter int IDX_W  = cache_pkg::DEF_IDX_W,
  parameter int DATA_W = cache_pkg::DEF_DATA_W,
  parameter int CNT_W  = cache_pkg::DEF_CNT_W
);
  logic              req_valid, req_ready, req_write;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_index;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid, resp_hit;
  logic [DATA_W-1:0] resp_data;
  logic [TAG_W-1:0]  resp_tag;
  logic              writeback;
  logic [5:0]        status;
  logic              mem_req, mem_we, mem_ack;
  logic [TAG_W+IDX_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [CNT_W-1:0]  hit_count, miss_count;
  modport slave (
    input  req_valid, req_write, req_tag, req_index, req_wdata, mem_rdata, mem_ack,
    output req_ready, resp_valid, resp_hit, resp_data, resp_tag, writeback, status,
           mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
  );
  modport master (
    output req_valid, req_write, req_tag, req_index, req_wdata, mem_rdata, mem_ack,
    input  req_ready, resp_valid, resp_hit, resp_data, resp_tag, writeback, status,
           mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
  );
endinterface

// File: rtl/cache_set_array.sv
// cache_set_array: 2-way tag/data/valid/dirty/LRU storage with tag compare, victim select and next-status view
module cache_set_array import cache_pkg::*; #(
  parameter int TAG_W  = DEF_TAG_W,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [IDX_W-1:0]  idx,
  input  logic [TAG_W-1:0]  tag,
  input  logic              way,
  input  logic              wr,
  input  logic              wdirty,
  input  logic              clr_dirty,
  input  logic              touch,
  input  logic [DATA_W-1:0] wdata,
  output logic              hit,
  output logic              hit_way,
  output logic              vic_way,
  output logic              vic_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  output logic [5:0]        st_next
);
  localparam int SETS = 2**IDX_W;
  logic [TAG_W-1:0]  tags [SETS][2];
  logic [DATA_W-1:0] data [SETS][2];
  logic [1:0]        valid [SETS];
  logic [1:0]        dirty [SETS];
  logic [SETS-1:0]   lru;
  logic [1:0]        hits, m, v_n, d_n;
  logic              l_n;
  assign hits[0]   = valid[idx][0] && tags[idx][0] == tag;
  assign hits[1]   = valid[idx][1] && tags[idx][1] == tag;
  assign hit       = |hits;
  assign hit_way   = !hits[0];
  assign vic_way   = !valid[idx][0] ? 1'b0 : !valid[idx][1] ? 1'b1 : lru[idx];
  assign vic_dirty = valid[idx][vic_way] && dirty[idx][vic_way];
  assign rd_tag    = tags[idx][way];
  assign rd_data   = data[idx][way];
  // next-cycle view of the set, so status can be captured together with the update
  assign m   = way ? 2'b10 : 2'b01;
  assign v_n = valid[idx] | (wr ? m : 2'b00);
  assign d_n = (dirty[idx] & ~((wr || clr_dirty) ? m : 2'b00)) | ((wr && wdirty) ? m : 2'b00);
  assign l_n = touch ? !way : lru[idx];
  always_comb begin
    st_next            = '0;
    st_next[ST_DIRTY1] = d_n[1];
    st_next[ST_DIRTY0] = d_n[0];
    st_next[ST_VALID1] = v_n[1];
    st_next[ST_VALID0] = v_n[0];
    st_next[ST_LRU1]   = l_n;
    st_next[ST_LRU0]   = !l_n;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < SETS; i++) begin
        valid[i] <= '0;
        dirty[i] <= '0;
      end
      lru <= '0;
    end else begin
      valid[idx] <= v_n;
      dirty[idx] <= d_n;
      lru[idx]   <= l_n;
    end
  always_ff @(posedge clock)
    if (wr) begin
      tags[idx][way] <= tag;
      data[idx][way] <= wdata;
    end
endmodule

// File: rtl/cache_controller.sv
// cache_controller: one-request-at-a-time write-back/write-allocate sequencer for a 4-set 2-way cache.
// Optional CACHE_STATS_EN adds saturating hit/miss counters; otherwise both counter ports read 0.
module cache_controller import cache_pkg::*; #(
  parameter int TAG_W  = DEF_TAG_W,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input logic   clock,
  input logic   reset_n,
  cache_if.slave bus
);
  state_t            state, nxt;
  logic              r_write, way_r, resp_hit_r;
  logic [TAG_W-1:0]  r_tag, resp_tag_r;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_wdata, resp_data_r, wdata;
  logic [5:0]        status_r, st_next;
  logic              hit, hit_way, vic_way, vic_dirty, way, wr, wdirty, clr_dirty, touch, go;
  logic [TAG_W-1:0]  rd_tag;
  logic [DATA_W-1:0] rd_data;
  cache_set_array #(.TAG_W(TAG_W), .IDX_W(IDX_W), .DATA_W(DATA_W)) u_array (
    .clock(clock), .reset_n(reset_n), .idx(r_idx), .tag(r_tag), .way(way), .wr(wr),
    .wdirty(wdirty), .clr_dirty(clr_dirty), .touch(touch), .wdata(wdata), .hit(hit),
    .hit_way(hit_way), .vic_way(vic_way), .vic_dirty(vic_dirty), .rd_tag(rd_tag),
    .rd_data(rd_data), .st_next(st_next)
  );
  assign way   = state == LOOKUP ? (hit ? hit_way : vic_way) : way_r;
  assign wdata = state == REFILL ? bus.mem_rdata : r_wdata;
  always_comb begin
    nxt       = state;
    wr        = 1'b0;
    wdirty    = 1'b1;
    clr_dirty = 1'b0;
    touch     = 1'b0;
    case (state)
      IDLE:      nxt = bus.req_valid ? LOOKUP : IDLE;
      LOOKUP: begin
        wr    = hit ? r_write : !vic_dirty && r_write;
        touch = hit || (!vic_dirty && r_write);
        nxt   = touch ? RESPOND : vic_dirty ? WRITEBACK : REFILL;
      end
      WRITEBACK: begin
        clr_dirty = bus.mem_ack;
        wr        = bus.mem_ack && r_write;
        touch     = wr;
        nxt       = !bus.mem_ack ? WRITEBACK : r_write ? RESPOND : REFILL;
      end
      REFILL: begin
        wr     = bus.mem_ack;
        wdirty = 1'b0;
        touch  = bus.mem_ack;
        nxt    = bus.mem_ack ? RESPOND : REFILL;
      end
      default:   nxt = IDLE;
    endcase
  end
  assign go = nxt == RESPOND && state != RESPOND;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state       <= IDLE;
      r_write     <= 1'b0;
      r_tag       <= '0;
      r_idx       <= '0;
      r_wdata     <= '0;
      way_r       <= 1'b0;
      resp_hit_r  <= 1'b0;
      resp_tag_r  <= '0;
      resp_data_r <= '0;
      status_r    <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && bus.req_valid) begin
        r_write <= bus.req_write;
        r_tag   <= bus.req_tag;
        r_idx   <= bus.req_index;
        r_wdata <= bus.req_wdata;
      end
      if (state == LOOKUP) way_r <= way;
      if (go) begin
        resp_hit_r  <= state == LOOKUP && hit;
        resp_tag_r  <= r_tag;
        resp_data_r <= wr ? wdata : rd_data;
        status_r    <= st_next;
      end
    end
  assign bus.req_ready  = state == IDLE;
  assign bus.resp_valid = state == RESPOND;
  assign bus.resp_hit   = resp_hit_r;
  assign bus.resp_tag   = resp_tag_r;
  assign bus.resp_data  = resp_data_r;
  assign bus.status     = status_r;
  assign bus.writeback  = state == WRITEBACK && bus.mem_ack;
  assign bus.mem_req    = state == WRITEBACK || state == REFILL;
  assign bus.mem_we     = state == WRITEBACK;
  assign bus.mem_addr   = state == WRITEBACK ? {rd_tag, r_idx} : state == REFILL ? {r_tag, r_idx} : '0;
  assign bus.mem_wdata  = state == WRITEBACK ? rd_data : '0;
`ifdef CACHE_STATS_EN
  logic [CNT_W-1:0] hit_cnt, miss_cnt;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == LOOKUP) begin
      if (hit) hit_cnt <= hit_cnt + CNT_W'(hit_cnt != '1);
      else miss_cnt <= miss_cnt + CNT_W'(miss_cnt != '1);
    end
  assign bus.hit_count  = hit_cnt;
  assign bus.miss_count = miss_cnt;
`else
  assign bus.hit_count  = {CNT_W{1'b0}};
  assign bus.miss_count = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed plus random requests checked against an array-based model of the cache rules
module tb_cache_controller;
  import cache_pkg::*;
  localparam int TW = DEF_TAG_W, IW = DEF_IDX_W, DW = DEF_DATA_W, CW = DEF_CNT_W, SETS = 4;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  cache_if bus ();
  cache_controller dut (.clock(clk), .reset_n(rst_n), .bus(bus));
  int nvec = 0, nerr = 0;
  logic [TW-1:0] m_tag [SETS][2];
  logic [DW-1:0] m_data [SETS][2];
  bit m_valid [SETS][2], m_dirty [SETS][2], m_lru [SETS];
  int m_hits, m_miss;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int exp_cnt(input int n);
`ifdef CACHE_STATS_EN
    return n;
`else
    return 0;
`endif
  endfunction
  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
      end
      m_lru[s] = 0;
    end
    m_hits = 0;
    m_miss = 0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    bus.req_valid = 0;
    bus.mem_ack = 0;
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask
  task automatic check_counts(input string tag);
    check({tag, "_hits"}, bus.hit_count, exp_cnt(m_hits));
    check({tag, "_misses"}, bus.miss_count, exp_cnt(m_miss));
  endtask
  // one full request; model is updated first, then DUT behaviour is compared cycle by cycle
  task automatic access(input bit wr, input logic [TW-1:0] t, input logic [IW-1:0] ix,
                        input logic [DW-1:0] wd, input logic [DW-1:0] rd, input int lat);
    int h = -1, v, c = 1, opi = 0, wc = 0, e_lat;
    bit done = 0, bad = 0, ack;
    bit op_we [$];
    logic [TW+IW-1:0] op_addr [$];
    logic [DW-1:0] op_wd [$];
    logic [DW-1:0] e_data;
    logic [5:0] e_stat;
    for (int w = 0; w < 2; w++) if (m_valid[ix][w] && m_tag[ix][w] == t) h = w;
    if (h >= 0) begin
      v = h;
      if (wr) begin
        m_data[ix][v] = wd;
        m_dirty[ix][v] = 1;
      end
      m_hits = m_hits < MAXC ? m_hits + 1 : m_hits;
    end else begin
      v = !m_valid[ix][0] ? 0 : !m_valid[ix][1] ? 1 : int'(m_lru[ix]);
      if (m_valid[ix][v] && m_dirty[ix][v]) begin
        op_we.push_back(1);
        op_addr.push_back({m_tag[ix][v], ix});
        op_wd.push_back(m_data[ix][v]);
      end
      if (!wr) begin
        op_we.push_back(0);
        op_addr.push_back({t, ix});
        op_wd.push_back('0);
      end
      m_tag[ix][v] = t;
      m_data[ix][v] = wr ? wd : rd;
      m_valid[ix][v] = 1;
      m_dirty[ix][v] = wr;
      m_miss = m_miss < MAXC ? m_miss + 1 : m_miss;
    end
    m_lru[ix] = (v == 0);
    e_data = m_data[ix][v];
    e_stat = {m_dirty[ix][1], m_dirty[ix][0], m_valid[ix][1], m_valid[ix][0], m_lru[ix], !m_lru[ix]};
    e_lat = 2 + op_we.size() * (lat + 1);
    check("req_ready", bus.req_ready, 1);
    bus.req_valid = 1;
    bus.req_write = wr;
    bus.req_tag = t;
    bus.req_index = ix;
    bus.req_wdata = wd;
    @(negedge clk);
    bus.req_write = 1'($urandom);
    bus.req_tag = TW'($urandom);
    bus.req_index = IW'($urandom);
    bus.req_wdata = DW'($urandom);
    bus.req_valid = 1'($urandom);
    bus.mem_ack = 1'($urandom);
    while (!done && !bad && c < 80) begin
      if (bus.resp_valid) begin
        bus.req_valid = 0;
        bus.mem_ack = 0;
        check("resp_hit", bus.resp_hit, h >= 0);
        check("resp_data", bus.resp_data, e_data);
        check("resp_tag", bus.resp_tag, t);
        check("status", bus.status, e_stat);
        check("latency", c, e_lat);
        check("mem_ops", opi, op_we.size());
        done = 1;
      end else begin
        if (bus.mem_req) begin
          if (opi >= op_we.size()) begin
            check("mem_unexpected", 1, 0);
            bad = 1;
          end else begin
            check("mem_we", bus.mem_we, op_we[opi]);
            check("mem_addr", bus.mem_addr, op_addr[opi]);
            if (op_we[opi]) check("mem_wdata", bus.mem_wdata, op_wd[opi]);
            ack = (wc == lat);
            bus.mem_ack = ack;
            bus.mem_rdata = rd;
            #1;
            check("writeback", bus.writeback, ack && op_we[opi]);
            if (ack) begin
              opi++;
              wc = 0;
            end else wc++;
          end
        end
        if (!bad) begin
          @(negedge clk);
          bus.mem_ack = 1'($urandom);
          bus.mem_rdata = DW'($urandom);
          bus.req_valid = 1'($urandom);
          c++;
        end
      end
    end
    if (!done) begin
      check("resp_timeout", c, e_lat);
      do_reset();
    end else begin
      @(negedge clk);
      check("resp_pulse", bus.resp_valid, 0);
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.req_valid = 0;
    bus.req_write = 0;
    bus.req_tag = '0;
    bus.req_index = '0;
    bus.req_wdata = '0;
    bus.mem_ack = 0;
    bus.mem_rdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_ready", bus.req_ready, 1);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_status", bus.status, 0);
    check("rst_resp_data", bus.resp_data, 0);
    check_counts("rst");
    rst_n = 1;
    @(negedge clk);
    access(0, 3'd3, 2'd1, 3'd0, 3'd6, 1);
    access(0, 3'd3, 2'd1, 3'd0, 3'd1, 0);
    access(1, 3'd3, 2'd1, 3'd2, 3'd0, 0);
    access(0, 3'd5, 2'd1, 3'd0, 3'd4, 0);
    access(0, 3'd7, 2'd1, 3'd0, 3'd1, 2);
    access(1, 3'd2, 2'd2, 3'd5, 3'd0, 0);
    access(0, 3'd1, 2'd0, 3'd0, 3'd3, 0);
    // abort a refill by reset while mem_ack is withheld
    bus.req_valid = 1;
    bus.req_write = 0;
    bus.req_tag = 3'd6;
    bus.req_index = 2'd3;
    @(negedge clk);
    bus.req_valid = 0;
    @(negedge clk);
    check("abort_pre_mem_req", bus.mem_req, 1);
    #2 rst_n = 0;
    #1;
    check("abort_mem_req", bus.mem_req, 0);
    check("abort_ready", bus.req_ready, 1);
    check("abort_resp_valid", bus.resp_valid, 0);
    check("abort_status", bus.status, 0);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    access(0, 3'd1, 2'd0, 3'd0, 3'd5, 0);
    repeat (3) access(0, 3'd1, 2'd0, 3'd0, 3'd0, 0);
    access(0, 3'd2, 2'd1, 3'd0, 3'd2, 1);
    check_counts("stats_3_2");
    repeat (300) access(0, 3'd1, 2'd0, 3'd0, 3'd0, 0);
    check_counts("stats_sat");
    for (int i = 0; i < 200; i++)
      access(1'($urandom), TW'($urandom), IW'($urandom), DW'($urandom), DW'($urandom), $urandom_range(2, 0));
    check_counts("final");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
